// File: rtl/pe2ddr_dispatch_pkg.sv
// Shared constants for the PE-to-DDR write-back dispatcher.
// Instruction field layout, opcode encodings and the dispatch FSM states.
package pe2ddr_dispatch_pkg;

  localparam int INST_W     = 64;
  localparam int DDR_ADDR_W = 32;
  localparam int BURST_W    = 16;

  localparam logic [3:0] OP_GATHER = 4'b0000;
  localparam int OP_PARAM_BIT = 3;
  localparam int OP_RSVD_BIT  = 2;

  localparam int OPC_LSB   = 58;
  localparam int BUF_LSB   = 52;
  localparam int CH_LSB    = 48;
  localparam int ROW_LSB   = 44;
  localparam int PIX_LSB   = 40;
  localparam int SIZE_LSB  = 40;
  localparam int SHIFT_LSB = 32;
  localparam int ADDR_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } disp_state_t;

  // Bits needed to hold the value n (never less than 1).
  function automatic int bw(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pe2ddr_dispatch_ins_fifo.sv
// Instruction queue: synchronous FIFO with full/empty flags.
// Storage is not reset; only the pointers are.
module pe2ddr_ins_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             wr;
  logic             rd;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign rdata = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pe2ddr_dispatch.sv
// PE-to-DDR write-back dispatcher: queues instructions, decodes them into
// gather / address-buffer / DDR channel configs, pulses starts, tracks dones.
module pe2ddr_dispatch
  import pe2ddr_dispatch_pkg::*;
#(
  parameter int PE_NUM = 32,
  parameter int DDR_CH = 2,
  parameter int QDEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   layer_type,
  input  logic [3:0]                   out_ch_seg,
  input  logic [7:0]                   img_width,
  input  logic [INST_W-1:0]            ins,
  input  logic                         ins_valid,
  output logic                         ins_ready,
  output logic [bw(PE_NUM/4)-1:0]      rd_sel,
  output logic                         path_sel,
  output logic                         dg_start,
  input  logic                         dg_done,
  output logic [3:0]                   dg_conf_pix_num,
  output logic [3:0]                   dg_conf_row_num,
  output logic [5:0]                   dg_conf_shift,
  output logic [1:0]                   dg_conf_pe_sel,
  output logic                         ab_start,
  input  logic                         ab_done,
  output logic [1:0]                   ab_conf_trans_type,
  output logic [7:0]                   ab_conf_trans_num,
  output logic [1:0]                   ab_conf_grp_sel,
  output logic [DDR_CH-1:0]            ddr_start,
  input  logic [DDR_CH-1:0]            ddr_done,
  output logic [DDR_CH*DDR_ADDR_W-1:0] ddr_st_addr,
  output logic [DDR_CH*DDR_ADDR_W-1:0] ddr_step,
  output logic [DDR_CH*BURST_W-1:0]    ddr_burst,
  output logic [DDR_CH*BURST_W-1:0]    ddr_burst_num,
  output logic                         busy,
  output logic                         err
);

  localparam int RS_W = bw(PE_NUM / 4);
  localparam int CS_W = bw(DDR_CH);
  localparam int NE   = DDR_CH + 2;

  disp_state_t       state;
  logic [NE-1:0]     pend;
  logic [NE-1:0]     done_v;
  logic [INST_W-1:0] head;
  logic              full;
  logic              empty;
  logic              pop;
  logic              rdy_q;

  pe2ddr_ins_fifo #(
    .WIDTH(INST_W),
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (ins_valid && ins_ready),
    .wdata(ins),
    .pop  (pop),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  assign ins_ready = rdy_q && !full;
  assign pop       = (state == ST_IDLE) && !empty;
  assign busy      = !empty || (state != ST_IDLE);
  assign done_v    = {ddr_done, ab_done, dg_done};

  logic [3:0]        opc;
  logic [5:0]        buf_id;
  logic [CS_W-1:0]   ch_sel;
  logic [3:0]        row_n;
  logic [3:0]        pix_n;
  logic [7:0]        size;
  logic [5:0]        shift;
  logic [31:0]       st_addr;
  logic              is_gather;
  logic              is_ab;
  logic              is_param;
  logic              bad;
  logic [DDR_CH-1:0] ddr_m;
  logic [31:0]       g_burst;
  logic [31:0]       g_step;
  logic [31:0]       p_len;
  logic [1:0]        pe_d;
  logic [RS_W-1:0]   rs_d;
  logic              unused;

  assign unused = ^{head[63:62], head[51:50],
                    head[39:38], layer_type[3]};

  always_comb begin
    opc       = head[OPC_LSB +: 4];
    buf_id    = head[BUF_LSB +: 6];
    ch_sel    = head[CH_LSB +: CS_W];
    row_n     = head[ROW_LSB +: 4];
    pix_n     = head[PIX_LSB +: 4];
    size      = head[SIZE_LSB +: 8];
    shift     = head[SHIFT_LSB +: 6];
    st_addr   = head[ADDR_LSB +: 32];
    is_param  = opc[OP_PARAM_BIT];
    is_ab     = !opc[OP_PARAM_BIT] && !opc[OP_RSVD_BIT];
    is_gather = (opc == OP_GATHER);
    bad       = (!opc[OP_PARAM_BIT] && opc[OP_RSVD_BIT]) ||
                (is_param && (int'(ch_sel) >= DDR_CH));
    g_burst   = ((32'(pix_n) + 32'd1) * 32'(out_ch_seg)) << 5;
    g_step    = ((32'(pix_n) + 32'd1) * 32'(img_width)) << 5;
    p_len     = layer_type[1] ? (32'(size) + 32'd1)
                              : ((32'(size) + 32'd1) << 5);
    pe_d      = layer_type[0] ? 2'b00 : buf_id[1:0];
    rs_d      = layer_type[0] ? RS_W'(buf_id >> 2) : RS_W'(buf_id);
    ddr_m     = '0;
    // Gather drives ch0 and, for plain layers, ch1; params hit ch_sel.
    for (int c = 0; c < DDR_CH; c++) begin
      ddr_m[c] = (is_gather && (c == 0 ||
                  (c == 1 && layer_type[2:1] == 2'b00))) ||
                 (is_param && int'(ch_sel) == c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= ST_IDLE;
      pend               <= '0;
      rdy_q              <= 1'b0;
      err                <= 1'b0;
      dg_start           <= 1'b0;
      ab_start           <= 1'b0;
      ddr_start          <= '0;
      rd_sel             <= '0;
      path_sel           <= 1'b0;
      dg_conf_pix_num    <= '0;
      dg_conf_row_num    <= '0;
      dg_conf_shift      <= '0;
      dg_conf_pe_sel     <= '0;
      ab_conf_trans_type <= '0;
      ab_conf_trans_num  <= '0;
      ab_conf_grp_sel    <= '0;
      ddr_st_addr        <= '0;
      ddr_step           <= '0;
      ddr_burst          <= '0;
      ddr_burst_num      <= '0;
    end else begin
      rdy_q     <= 1'b1;
      dg_start  <= 1'b0;
      ab_start  <= 1'b0;
      ddr_start <= '0;
      unique case (state)
        ST_IDLE: begin
          if (!empty) begin
            if (bad) begin
              err <= 1'b1;
            end else begin
              state     <= ST_ISSUE;
              pend      <= {ddr_m, is_ab, is_gather};
              dg_start  <= is_gather;
              ab_start  <= is_ab;
              ddr_start <= ddr_m;
              rd_sel    <= rs_d;
              if (is_ab) begin
                path_sel           <= !is_gather;
                ab_conf_trans_type <= opc[1:0];
                ab_conf_trans_num  <= size;
                ab_conf_grp_sel    <= buf_id[1:0];
              end
              if (is_gather) begin
                dg_conf_pix_num <= pix_n;
                dg_conf_row_num <= row_n;
                dg_conf_shift   <= shift;
                dg_conf_pe_sel  <= pe_d;
              end
              for (int c = 0; c < DDR_CH; c++) begin
                if (ddr_m[c]) begin
                  ddr_st_addr[c*DDR_ADDR_W +: DDR_ADDR_W] <=
                    DDR_ADDR_W'(st_addr);
                  ddr_step[c*DDR_ADDR_W +: DDR_ADDR_W] <= is_param ?
                    DDR_ADDR_W'(p_len) : DDR_ADDR_W'(g_step);
                  ddr_burst[c*BURST_W +: BURST_W] <= is_param ?
                    BURST_W'(p_len) : BURST_W'(g_burst);
                  ddr_burst_num[c*BURST_W +: BURST_W] <= is_param ?
                    (layer_type[0] ? BURST_W'(2) : BURST_W'(0)) :
                    BURST_W'(row_n);
                end
              end
            end
          end
        end
        ST_ISSUE: begin
          pend  <= pend & ~done_v;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          pend <= pend & ~done_v;
          if ((pend & ~done_v) == '0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe2ddr_dispatch.sv
// Scoreboard bench for pe2ddr_dispatch: stimulus queues expected issues,
// a negedge monitor checks every start pulse against them.
module tb_pe2ddr_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  layer_type;
  logic [3:0]  out_ch_seg;
  logic [7:0]  img_width;
  logic [63:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic [3:0]  rd_sel;
  logic        path_sel;
  logic        dg_start, dg_done;
  logic [3:0]  dg_pix, dg_row;
  logic [5:0]  dg_sh;
  logic [1:0]  dg_pe;
  logic        ab_start, ab_done;
  logic [1:0]  ab_tt;
  logic [7:0]  ab_tn;
  logic [1:0]  ab_gs;
  logic [1:0]  ddr_start, ddr_done;
  logic [63:0] ddr_st_addr, ddr_step;
  logic [31:0] ddr_burst, ddr_burst_num;
  logic        busy, err;

  logic [3:0]  dv = 4'b0;
  int          dly [4] = '{1, 1, 1, 1};
  int          cnt [4] = '{-1, -1, -1, -1};
  int          checks = 0;
  int          errors = 0;
  int          nstarts = 0;

  typedef struct {
    logic [3:0]  m;
    logic [3:0]  rd;
    logic        path;
    logic [3:0]  pix, row;
    logic [5:0]  sh;
    logic [1:0]  pe, tt, gs;
    logic [7:0]  tn;
    logic [31:0] sa0, sa1, st0, st1;
    logic [15:0] bu0, bu1, bn0, bn1;
  } exp_t;

  exp_t sb [$];

  pe2ddr_dispatch #(.PE_NUM(32), .DDR_CH(2), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .layer_type(layer_type), .out_ch_seg(out_ch_seg),
    .img_width(img_width),
    .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .rd_sel(rd_sel), .path_sel(path_sel),
    .dg_start(dg_start), .dg_done(dg_done),
    .dg_conf_pix_num(dg_pix), .dg_conf_row_num(dg_row),
    .dg_conf_shift(dg_sh), .dg_conf_pe_sel(dg_pe),
    .ab_start(ab_start), .ab_done(ab_done),
    .ab_conf_trans_type(ab_tt), .ab_conf_trans_num(ab_tn),
    .ab_conf_grp_sel(ab_gs),
    .ddr_start(ddr_start), .ddr_done(ddr_done),
    .ddr_st_addr(ddr_st_addr), .ddr_step(ddr_step),
    .ddr_burst(ddr_burst), .ddr_burst_num(ddr_burst_num),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  assign {ddr_done, ab_done, dg_done} = dv;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(
    input logic [3:0] op, input logic [5:0] b, input logic [1:0] ch,
    input logic [3:0] row, input logic [3:0] pix,
    input logic [5:0] sh, input logic [31:0] a);
    return {2'b0, op, b, 2'b0, ch, row, pix, 2'b0, sh, a};
  endfunction

  // Engine model: done pulses dly[e] cycles after each start (0 = same cycle).
  always @(negedge clk) begin
    for (int e = 0; e < 4; e++) begin
      dv[e] = 1'b0;
      if (cnt[e] == 0) begin
        dv[e] = 1'b1;
        cnt[e] = -1;
      end else if (cnt[e] > 0) begin
        cnt[e]--;
      end
      if (!rst && {ddr_start, ab_start, dg_start}[e]) begin
        if (dly[e] == 0) dv[e] = 1'b1;
        else cnt[e] = dly[e] - 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (dg_start || ab_start || (|ddr_start))) begin
      nstarts++;
      chk("start_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("mon_mask", {ddr_start, ab_start, dg_start}, e.m);
        chk("mon_rd_sel", rd_sel, e.rd);
        chk("mon_path_sel", path_sel, e.path);
        if (e.m[0]) begin
          chk("mon_dg_pix", dg_pix, e.pix);
          chk("mon_dg_row", dg_row, e.row);
          chk("mon_dg_shift", dg_sh, e.sh);
          chk("mon_dg_pe_sel", dg_pe, e.pe);
        end
        if (e.m[1]) begin
          chk("mon_ab_type", ab_tt, e.tt);
          chk("mon_ab_num", ab_tn, e.tn);
          chk("mon_ab_grp", ab_gs, e.gs);
        end
        if (e.m[2]) begin
          chk("mon_ddr0_addr", ddr_st_addr[31:0], e.sa0);
          chk("mon_ddr0_step", ddr_step[31:0], e.st0);
          chk("mon_ddr0_burst", ddr_burst[15:0], e.bu0);
          chk("mon_ddr0_bnum", ddr_burst_num[15:0], e.bn0);
        end
        if (e.m[3]) begin
          chk("mon_ddr1_addr", ddr_st_addr[63:32], e.sa1);
          chk("mon_ddr1_step", ddr_step[63:32], e.st1);
          chk("mon_ddr1_burst", ddr_burst[31:16], e.bu1);
          chk("mon_ddr1_bnum", ddr_burst_num[31:16], e.bn1);
        end
      end
    end
  end

  task automatic push(input logic [63:0] w);
    int n = 0;
    ins = w;
    ins_valid = 1'b1;
    while (!ins_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_accepted", n < 50, 1);
    @(negedge clk);
    ins_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", n < budget, 1);
  endtask

  task automatic set_dly(input int a, input int b,
                         input int c, input int d);
    dly[0] = a; dly[1] = b; dly[2] = c; dly[3] = d;
  endtask

  function automatic logic [63:0] out_bits();
    return {32'(rd_sel), 31'(ddr_burst), path_sel} ^
           {ddr_st_addr[31:0] | ddr_step[31:0],
            ddr_burst_num, dg_pix, dg_row, dg_sh, dg_pe,
            ab_tt, ab_tn, ab_gs};
  endfunction

  initial begin
    exp_t e;
    int ns;
    layer_type = 4'b0000;
    out_ch_seg = 4'd2;
    img_width  = 8'd16;
    ins        = '0;
    ins_valid  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", ins_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_starts", {ddr_start, ab_start, dg_start}, 0);
    chk("rst_conf", out_bits(), 0);
    rst = 1'b0;
    #1 chk("rel_ready_before_clk", ins_ready, 0);
    @(negedge clk);
    chk("rel_ready_after_clk", ins_ready, 1);

    // Gather with staggered dones: ddr1 in ISSUE, then ab, dg, ddr0.
    set_dly(10, 5, 15, 0);
    e = '{default: '0};
    e.m = 4'hF; e.rd = 4'd6; e.path = 1'b0;
    e.pix = 4'd3; e.row = 4'd7; e.sh = 6'd5; e.pe = 2'd2;
    e.tt = 2'd0; e.tn = 8'h73; e.gs = 2'd2;
    e.sa0 = 32'h8000; e.sa1 = 32'h8000;
    e.st0 = 32'd2048; e.st1 = 32'd2048;
    e.bu0 = 16'd256;  e.bu1 = 16'd256;
    e.bn0 = 16'd7;    e.bn1 = 16'd7;
    sb.push_back(e);
    push(mk(4'b0000, 6'd6, 2'd0, 4'd7, 4'd3, 6'd5, 32'h8000));
    @(negedge clk);
    chk("gather_latency_t2", {ddr_start, ab_start, dg_start}, 4'hF);
    repeat (15) @(negedge clk);
    chk("busy_until_last_done", busy, 1);
    @(negedge clk);
    chk("busy_drops_after", busy, 0);

    // Parameter transfers to channel 1.
    set_dly(2, 2, 2, 2);
    layer_type = 4'b0010;
    e = '{default: '0};
    e.m = 4'b1000; e.rd = 4'd4; e.path = 1'b0;
    e.sa1 = 32'h1000; e.st1 = 32'd10; e.bu1 = 16'd10; e.bn1 = 16'd0;
    sb.push_back(e);
    push(mk(4'b1000, 6'd4, 2'd1, 4'd0, 4'd9, 6'd0, 32'h1000));
    wait_idle(100);
    layer_type = 4'b0001;
    e.rd = 4'd1; e.st1 = 32'd320; e.bu1 = 16'd320; e.bn1 = 16'd2;
    sb.push_back(e);
    push(mk(4'b1000, 6'd4, 2'd1, 4'd0, 4'd9, 6'd0, 32'h1000));
    wait_idle(100);

    // Backpressure: five ab transfers against a slow engine.
    layer_type = 4'b0010;
    set_dly(20, 20, 20, 20);
    for (int i = 0; i < 5; i++) begin
      e = '{default: '0};
      e.m = 4'b0010; e.rd = 4'(i + 1); e.path = 1'b1;
      e.tt = 2'd2; e.tn = 8'(8'h40 + i); e.gs = 2'(i + 1);
      sb.push_back(e);
    end
    for (int i = 0; i < 5; i++)
      push(mk(4'b0010, 6'(i + 1), 2'd0, 4'd4, 4'(i), 6'd0, 32'h0));
    chk("bp_ready_low_full", ins_ready, 0);
    wait_idle(400);
    chk("bp_ready_restored", ins_ready, 1);

    // Malformed instructions followed by a valid one.
    set_dly(2, 2, 2, 2);
    chk("err_clear_before", err, 0);
    push(mk(4'b0100, 6'd1, 2'd0, 4'd1, 4'd1, 6'd0, 32'h0));
    @(negedge clk);
    chk("err_set_rsvd_op", err, 1);
    e = '{default: '0};
    e.m = 4'b0010; e.rd = 4'd5; e.path = 1'b1;
    e.tt = 2'd1; e.tn = 8'h22; e.gs = 2'd1;
    sb.push_back(e);
    push(mk(4'b1000, 6'd0, 2'd3, 4'd0, 4'd5, 6'd0, 32'h0));
    push(mk(4'b0001, 6'd5, 2'd0, 4'd2, 4'd2, 6'd0, 32'h0));
    wait_idle(100);
    chk("err_sticky", err, 1);

    // Async reset mid-WAIT with two instructions still queued.
    set_dly(50, 50, 50, 50);
    e = '{default: '0};
    e.m = 4'b0100; e.rd = 4'd2; e.path = 1'b1;
    e.sa0 = 32'h2000; e.st0 = 32'd2; e.bu0 = 16'd2; e.bn0 = 16'd0;
    sb.push_back(e);
    push(mk(4'b1000, 6'd2, 2'd0, 4'd0, 4'd1, 6'd0, 32'h2000));
    push(mk(4'b1000, 6'd3, 2'd1, 4'd0, 4'd2, 6'd0, 32'h3000));
    push(mk(4'b0001, 6'd7, 2'd0, 4'd0, 4'd3, 6'd0, 32'h0));
    repeat (3) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    chk("abort_ready", ins_ready, 0);
    chk("abort_starts", {ddr_start, ab_start, dg_start}, 0);
    chk("abort_conf", out_bits(), 0);
    ns = nstarts;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", ins_ready, 1);
    repeat (60) @(negedge clk);
    chk("abort_idle", busy, 0);
    chk("abort_no_stale_start", nstarts - ns, 0);

    // Normal operation after reset.
    set_dly(1, 1, 1, 1);
    e = '{default: '0};
    e.m = 4'b0100; e.rd = 4'd3; e.path = 1'b0;
    e.sa0 = 32'hABC; e.st0 = 32'd4; e.bu0 = 16'd4; e.bn0 = 16'd0;
    sb.push_back(e);
    push(mk(4'b1000, 6'd3, 2'd0, 4'd0, 4'd3, 6'd0, 32'hABC));
    wait_idle(100);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
